// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and baud divider helper
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  // Rounded clock cycles per oversample tick.
  function automatic int baud_div(input longint clk_hz, input longint baud, input longint os);
    return int'((clk_hz + (baud * os) / 2) / (baud * os));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO, power-of-two depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  // A pop on a full FIFO frees the slot the same-cycle push needs.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver with parity/frame checks feeding a receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          UART_RX,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TC_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(OVERSAMPLE - 1);
  localparam logic [TC_W-1:0]  TC_S0    = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  TC_S1    = TC_W'(OVERSAMPLE / 2);
  localparam logic [TC_W-1:0]  TC_S2    = TC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_BITS - 1);

  rx_state_t             r_state;
  rx_state_t             w_next;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  logic [DIV_W-1:0]      r_div;
  logic [TC_W-1:0]       r_tc;
  logic                  r_v0;
  logic                  r_v1;
  logic [BC_W-1:0]       r_bitcnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_err;
  logic                  r_push;
  logic [DATA_BITS-1:0]  r_push_data;
  logic                  r_frame_err;
  logic                  r_parity_err;
  logic                  r_overrun;

  logic                  w_fall;
  logic                  w_tick;
  logic                  w_bit_end;
  logic                  w_vote_pt;
  logic                  w_vote;
  logic                  w_par_exp;
  logic                  w_push_req;
  logic                  w_ferr;
  logic                  w_perr;
  logic                  w_full;
  logic                  w_empty;

  assign w_fall    = r_prev & ~r_sync2;
  assign w_tick    = (r_div == DIV_LAST);
  assign w_bit_end = w_tick && (r_tc == TC_LAST);
  assign w_vote_pt = w_tick && (r_tc == TC_S2);
  assign w_vote    = (r_v0 & r_v1) | (r_v0 & r_sync2) | (r_v1 & r_sync2);
  assign w_par_exp = (PARITY == PAR_ODD) ? ~(^r_shift) : ^r_shift;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_push_req = 1'b0;
    w_ferr     = 1'b0;
    w_perr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_next = S_START;
      end
      S_START: begin
        if (w_vote_pt && w_vote) w_next = S_IDLE;
        else if (w_bit_end)      w_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_bitcnt == BC_LAST)) begin
          w_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        // Leave at the vote so a back-to-back start edge is not missed.
        if (w_vote_pt) begin
          if (w_vote) begin
            w_next     = S_IDLE;
            w_push_req = ~r_par_err;
            w_perr     = r_par_err;
          end else begin
            w_next = S_BREAK;
            w_ferr = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (r_sync2) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_prev       <= 1'b1;
      r_div        <= '0;
      r_tc         <= '0;
      r_v0         <= 1'b1;
      r_v1         <= 1'b1;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync1 <= UART_RX;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if ((r_state == S_IDLE) && w_fall) begin
        r_div <= '0;
        r_tc  <= '0;
      end else begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_tick) r_tc <= (r_tc == TC_LAST) ? '0 : r_tc + TC_W'(1);
      end

      if (w_tick && (r_tc == TC_S0)) r_v0 <= r_sync2;
      if (w_tick && (r_tc == TC_S1)) r_v1 <= r_sync2;

      if (r_state != S_DATA)         r_bitcnt <= '0;
      else if (w_bit_end)            r_bitcnt <= r_bitcnt + BC_W'(1);

      if ((r_state == S_DATA) && w_vote_pt) begin
        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      end

      if (r_state == S_START)                       r_par_err <= 1'b0;
      else if ((r_state == S_PARITY) && w_vote_pt)  r_par_err <= (w_vote != w_par_exp);

      r_push       <= w_push_req;
      r_push_data  <= r_shift;
      r_frame_err  <= w_ferr;
      r_parity_err <= w_perr;
      r_overrun    <= r_push & w_full & ~rd_en;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sysclk),
    .i_reset (reset),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (rd_en),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign rx_valid   = ~w_empty;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized and directed bench for uart_rx_fifo against a byte-level model
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_a = 1'b1;
  logic       line_b = 1'b1;
  logic       rd_a = 1'b0;
  logic       rd_b = 1'b0;
  logic [7:0] dat_a, dat_b;
  logic       vld_a, vld_b;
  logic [2:0] cnt_a, cnt_b;
  logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

  int total = 0;
  int bad = 0;
  int got_fe[2], got_pe[2], got_ov[2];
  int exp_fe[2], exp_pe[2], exp_ov[2];
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_HZ(614400), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .FIFO_DEPTH(4)) u_a (
    .sysclk(clk), .reset(rst), .UART_RX(line_a), .rd_en(rd_a),
    .rx_data(dat_a), .rx_valid(vld_a), .fifo_count(cnt_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

  uart_rx_fifo #(.CLK_HZ(614400), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .FIFO_DEPTH(4)) u_b (
    .sysclk(clk), .reset(rst), .UART_RX(line_b), .rd_en(rd_b),
    .rx_data(dat_b), .rx_valid(vld_b), .fifo_count(cnt_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

  always @(negedge clk) begin
    if (!rst) begin
      if (fe_a) got_fe[0]++;
      if (pe_a) got_pe[0]++;
      if (ov_a) got_ov[0]++;
      if (fe_b) got_fe[1]++;
      if (pe_b) got_pe[1]++;
      if (ov_b) got_ov[1]++;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input int cyc);
    if (sel == 0) line_a = v;
    else          line_b = v;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Model: a good frame lands in the queue unless the queue is already full.
  task automatic frame(input int sel, input logic [7:0] d, input logic pbit, input logic stp);
    drive(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
    if (sel == 1) drive(sel, pbit, BIT);
    drive(sel, stp, BIT);
    if (!stp)                                      exp_fe[sel]++;
    else if (sel == 1 && pbit != ($countones(d) % 2 == 1)) exp_pe[sel]++;
    else if (sel == 0) begin
      if (q_a.size() == 4) exp_ov[0]++; else q_a.push_back(d);
    end else begin
      if (q_b.size() == 4) exp_ov[1]++; else q_b.push_back(d);
    end
  endtask

  task automatic pop(input int sel);
    @(negedge clk);
    if (sel == 0) rd_a = 1'b1; else rd_b = 1'b1;
    @(posedge clk);
    #1;
    rd_a = 1'b0;
    rd_b = 1'b0;
    if (sel == 0 && q_a.size() > 0) void'(q_a.pop_front());
    if (sel == 1 && q_b.size() > 0) void'(q_b.pop_front());
  endtask

  task automatic check_state(input int s, input string tag);
    int n;
    int hd;
    hd = 0;
    if (s == 0) begin
      n = q_a.size();
      if (n > 0) hd = int'(q_a[0]);
      check_eq({tag, "_cnt"}, int'(cnt_a), n);
      check_eq({tag, "_vld"}, int'(vld_a), int'(n > 0));
      if (n > 0) check_eq({tag, "_dat"}, int'(dat_a), hd);
    end else begin
      n = q_b.size();
      if (n > 0) hd = int'(q_b[0]);
      check_eq({tag, "_cnt"}, int'(cnt_b), n);
      check_eq({tag, "_vld"}, int'(vld_b), int'(n > 0));
      if (n > 0) check_eq({tag, "_dat"}, int'(dat_b), hd);
    end
    check_eq({tag, "_fe"}, got_fe[s], exp_fe[s]);
    check_eq({tag, "_pe"}, got_pe[s], exp_pe[s]);
    check_eq({tag, "_ov"}, got_ov[s], exp_ov[s]);
  endtask

  initial begin
    logic [7:0] td;
    logic [7:0] rd;
    logic       stp;
    logic       pb;
    int         s;
    bit         seen;

    for (int i = 0; i < 2; i++) begin
      got_fe[i] = 0; got_pe[i] = 0; got_ov[i] = 0;
      exp_fe[i] = 0; exp_pe[i] = 0; exp_ov[i] = 0;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_vld", int'(vld_a), 0);
    check_eq("rst_cnt", int'(cnt_a), 0);
    check_eq("rst_dat", int'(dat_a), 0);
    check_eq("rst_errs", int'({fe_a, pe_a, ov_a, fe_b, pe_b, ov_b}), 0);
    rst = 1'b0;
    drive(0, 1'b1, BIT * 2);

    // Single 8N1 frame: nothing before the stop bit, valid well inside it.
    td = 8'h55;
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(0, td[i], BIT);
    check_eq("t1_pre_vld", int'(vld_a), 0);
    drive(0, 1'b1, 56);
    check_eq("t1_vld", int'(vld_a), 1);
    check_eq("t1_dat", int'(dat_a), 8'h55);
    check_eq("t1_cnt", int'(cnt_a), 1);
    drive(0, 1'b1, BIT - 56 + BIT);
    q_a.push_back(8'h55);
    pop(0);
    pop(0);
    check_state(0, "t1_drain");

    // Back-to-back fill, then one more frame overruns.
    frame(0, 8'h55, 1'b0, 1'b1);
    frame(0, 8'hFF, 1'b0, 1'b1);
    frame(0, 8'hFA, 1'b0, 1'b1);
    frame(0, 8'hC6, 1'b0, 1'b1);
    frame(0, 8'h12, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    check_eq("t2_ov", got_ov[0], 1);
    check_state(0, "t2_full");
    for (int i = 0; i < 4; i++) begin
      pop(0);
      check_state(0, "t2_pop");
    end

    // Framing error with a held-low line, then recovery.
    frame(0, 8'hA5, 1'b0, 1'b0);
    drive(0, 1'b0, BIT * 2);
    drive(0, 1'b1, BIT * 2);
    check_eq("t3_fe", got_fe[0], 1);
    frame(0, 8'h3C, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    check_state(0, "t3_rx");
    pop(0);

    // Even parity: good then bad parity bit.
    drive(1, 1'b1, BIT * 2);
    frame(1, 8'h07, 1'b1, 1'b1);
    drive(1, 1'b1, BIT);
    check_state(1, "t4_good");
    frame(1, 8'h07, 1'b0, 1'b1);
    drive(1, 1'b1, BIT);
    check_eq("t4_pe", got_pe[1], 1);
    check_state(1, "t4_bad");
    pop(1);

    // 2-bit low glitch decodes as 0xFE; a 0.3-bit pulse is a false start.
    drive(0, 1'b0, BIT * 2);
    drive(0, 1'b1, BIT * 10);
    q_a.push_back(8'hFE);
    check_state(0, "t5_glitch");
    drive(0, 1'b0, 19);
    drive(0, 1'b1, BIT * 2);
    check_state(0, "t5_false");
    check_eq("t5_idle", int'(u_a.r_state), int'(S_IDLE));
    pop(0);

    // Reset mid-frame with two bytes held.
    frame(0, 8'h11, 1'b0, 1'b1);
    frame(0, 8'h22, 1'b0, 1'b1);
    td = 8'h5A;
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, td[i], BIT);
    drive(0, td[4], BIT / 2);
    rst = 1'b1;
    line_a = 1'b1;
    q_a.delete();
    q_b.delete();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b1, BIT * 2);
    check_eq("t6_rst_cnt", int'(cnt_a), 0);
    check_eq("t6_rst_vld", int'(vld_a), 0);
    frame(0, 8'h81, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    check_state(0, "t6_rx");

    // Fill to full, then pop on exactly the push cycle.
    frame(0, 8'h42, 1'b0, 1'b1);
    frame(0, 8'h43, 1'b0, 1'b1);
    frame(0, 8'h44, 1'b0, 1'b1);
    drive(0, 1'b1, BIT);
    check_state(0, "t6_full");
    seen = 1'b0;
    fork
      frame(0, 8'h99, 1'b0, 1'b1);
      begin
        for (int i = 0; i < BIT * 11 && !seen; i++) begin
          @(negedge clk);
          if (u_a.r_push) begin
            rd_a = 1'b1;
            @(posedge clk);
            #1;
            rd_a = 1'b0;
            void'(q_a.pop_front());
            seen = 1'b1;
          end
        end
      end
    join
    drive(0, 1'b1, BIT);
    check_eq("t6_pp_seen", int'(seen), 1);
    check_eq("t6_pp_cnt", int'(cnt_a), 4);
    check_state(0, "t6_pp");
    for (int i = 0; i < 5; i++) pop(0);

    // Randomized frames on both receivers with random pops.
    for (int it = 0; it < 24; it++) begin
      s   = int'($urandom_range(0, 1));
      rd  = 8'($urandom);
      stp = ($urandom_range(0, 7) != 0);
      pb  = ($countones(rd) % 2 == 1);
      if (s == 1 && $urandom_range(0, 4) == 0) pb = ~pb;
      frame(s, rd, pb, stp);
      drive(s, 1'b1, stp ? BIT / 2 : BIT * 2);
      check_state(s, "rnd");
      repeat ($urandom_range(0, 2)) pop(s);
      if ($urandom_range(0, 3) == 0) pop(1 - s);
    end
    check_state(0, "end_a");
    check_state(1, "end_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
